// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with a 2-entry skid buffer on the output side.
// Optional CSR zimm format (fmt 6) is compiled in when IMM_ZIMM_EN is defined.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      InInstr,
  input  logic [TAG_W-1:0] InTag,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [XLEN-1:0]  OutImm,
  output logic [2:0]       OutFmt,
  output logic             OutIllegal,
  output logic [TAG_W-1:0] OutTag
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam bit IS_RV64 = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t m_q, m_d;
  entry_t s_q, s_d;
  entry_t dec_entry;
  logic   out_valid_q, out_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   accept, drain;

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]      opcode;

  // Every candidate immediate is sign-extended from its top bit, which is always InInstr[31].
  assign imm_i  = XLEN'($signed(InInstr[31:20]));
  assign imm_s  = XLEN'($signed({InInstr[31:25], InInstr[11:7]}));
  assign imm_b  = XLEN'($signed({InInstr[31], InInstr[7], InInstr[30:25], InInstr[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({InInstr[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({InInstr[31], InInstr[19:12], InInstr[20], InInstr[30:21], 1'b0}));
  assign opcode = InInstr[6:0];

  always_comb begin
    dec_entry     = '0;
    dec_entry.tag = InTag;
    dec_entry.fmt = FMT_ILL;
    dec_entry.ill = 1'b1;
    if (InInstr[1:0] == 2'b11) begin
      unique case (opcode)
        OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
          dec_entry.fmt = FMT_I;
          dec_entry.ill = 1'b0;
          dec_entry.imm = imm_i;
        end
        OPC_OP_IMM_32: begin
          if (IS_RV64) begin
            dec_entry.fmt = FMT_I;
            dec_entry.ill = 1'b0;
            dec_entry.imm = imm_i;
          end
        end
        OPC_STORE: begin
          dec_entry.fmt = FMT_S;
          dec_entry.ill = 1'b0;
          dec_entry.imm = imm_s;
        end
        OPC_BRANCH: begin
          dec_entry.fmt = FMT_B;
          dec_entry.ill = 1'b0;
          dec_entry.imm = imm_b;
        end
        OPC_LUI, OPC_AUIPC: begin
          dec_entry.fmt = FMT_U;
          dec_entry.ill = 1'b0;
          dec_entry.imm = imm_u;
        end
        OPC_JAL: begin
          dec_entry.fmt = FMT_J;
          dec_entry.ill = 1'b0;
          dec_entry.imm = imm_j;
        end
        OPC_OP: begin
          dec_entry.fmt = FMT_R;
          dec_entry.ill = 1'b0;
        end
        OPC_OP_32: begin
          if (IS_RV64) begin
            dec_entry.fmt = FMT_R;
            dec_entry.ill = 1'b0;
          end
        end
        OPC_SYSTEM: begin
          dec_entry.ill = 1'b0;
`ifdef IMM_ZIMM_EN
          // funct3[2] selects the immediate CSR forms; rs1 field carries an unsigned 5-bit uimm.
          if (InInstr[14]) begin
            dec_entry.fmt = 3'd6;
            dec_entry.imm = XLEN'(InInstr[19:15]);
          end else begin
            dec_entry.fmt = FMT_I;
            dec_entry.imm = imm_i;
          end
`else
          dec_entry.fmt = FMT_I;
          dec_entry.imm = imm_i;
`endif
        end
        default: begin
          dec_entry.fmt = FMT_ILL;
          dec_entry.ill = 1'b1;
        end
      endcase
    end
  end

  assign accept = InValid && in_ready_q && !Flush;
  assign drain  = out_valid_q && OutReady;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          m_d     = dec_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          m_d = dec_entry;
        end else if (accept) begin
          s_d     = dec_entry;
          state_d = ST_TWO;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drain) begin
          m_d     = s_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (Flush) begin
      state_d = ST_EMPTY;
    end
    // Handshake flags are registered copies of the next state so no output is combinational.
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_TWO);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_EMPTY;
      m_q         <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign InReady    = in_ready_q;
  assign OutValid   = out_valid_q;
  assign OutImm     = m_q.imm;
  assign OutFmt     = m_q.fmt;
  assign OutIllegal = m_q.ill;
  assign OutTag     = m_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: RV32 and RV64 instances share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic        r32_in_ready, r32_out_valid, r32_ill;
  logic [31:0] r32_imm;
  logic [2:0]  r32_fmt;
  logic [3:0]  r32_tag;

  logic        r64_in_ready, r64_out_valid, r64_ill;
  logic [63:0] r64_imm;
  logic [2:0]  r64_fmt;
  logic [3:0]  r64_tag;

  int checks;
  int failures;

  imm_gen_pipe #(.XLEN(32), .TAG_W(4)) u32 (
    .Clock(clk), .Reset(rst_n), .Flush(flush),
    .InValid(in_valid), .InReady(r32_in_ready), .InInstr(in_instr), .InTag(in_tag),
    .OutValid(r32_out_valid), .OutReady(out_ready), .OutImm(r32_imm),
    .OutFmt(r32_fmt), .OutIllegal(r32_ill), .OutTag(r32_tag)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(4)) u64 (
    .Clock(clk), .Reset(rst_n), .Flush(flush),
    .InValid(in_valid), .InReady(r64_in_ready), .InInstr(in_instr), .InTag(in_tag),
    .OutValid(r64_out_valid), .OutReady(out_ready), .OutImm(r64_imm),
    .OutFmt(r64_fmt), .OutIllegal(r64_ill), .OutTag(r64_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_tag    = 4'h0;
    out_ready = 1'b1;

    vecs[0]  = '{"addi_m1",   32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    vecs[1]  = '{"lui",       32'h12345037, 32'h12345000, 3'd4, 1'b0, 64'h0000000012345000, 3'd4, 1'b0};
    vecs[2]  = '{"jal_8",     32'h0080006F, 32'h00000008, 3'd5, 1'b0, 64'h0000000000000008, 3'd5, 1'b0};
    vecs[3]  = '{"beq_m4",    32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
    vecs[4]  = '{"sw_m8",     32'hFE20AC23, 32'hFFFFFFF8, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0};
    vecs[5]  = '{"zero_word", 32'h00000000, 32'h00000000, 3'd7, 1'b1, 64'h0,                3'd7, 1'b1};
    vecs[6]  = '{"opc_7f",    32'h0000007F, 32'h00000000, 3'd7, 1'b1, 64'h0,                3'd7, 1'b1};
    vecs[7]  = '{"op32",      32'h0000003B, 32'h00000000, 3'd7, 1'b1, 64'h0,                3'd0, 1'b0};
`ifdef IMM_ZIMM_EN
    vecs[8]  = '{"csrrwi",    32'h3402D073, 32'h00000005, 3'd6, 1'b0, 64'h0000000000000005, 3'd6, 1'b0};
`else
    vecs[8]  = '{"csrrwi",    32'h3402D073, 32'h00000340, 3'd1, 1'b0, 64'h0000000000000340, 3'd1, 1'b0};
`endif
    vecs[9]  = '{"addiw_m1",  32'hFFF0009B, 32'h00000000, 3'd7, 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    vecs[10] = '{"lui_neg",   32'hFFFFF0B7, 32'hFFFFF000, 3'd4, 1'b0, 64'hFFFFFFFFFFFFF000, 3'd4, 1'b0};
    vecs[11] = '{"low_bits",  32'hFFF00091, 32'h00000000, 3'd7, 1'b1, 64'h0,                3'd7, 1'b1};
    vecs[12] = '{"add_r",     32'h00208033, 32'h00000000, 3'd0, 1'b0, 64'h0,                3'd0, 1'b0};
    vecs[13] = '{"jalr_min",  32'h80000067, 32'hFFFFF800, 3'd1, 1'b0, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b0};

    // Reset state while held.
    step();
    step();
    chk("rst_out_valid", {63'b0, r32_out_valid}, 64'd0);
    chk("rst_in_ready",  {63'b0, r32_in_ready},  64'd0);
    chk("rst_imm",       {32'b0, r32_imm},       64'd0);
    chk("rst_fmt",       {61'b0, r32_fmt},       64'd0);
    chk("rst_tag",       {60'b0, r32_tag},       64'd0);
    chk("rst_ill",       {63'b0, r32_ill},       64'd0);
    rst_n = 1'b1;
    step();
    chk("rel_in_ready",  {63'b0, r32_in_ready},  64'd1);
    chk("rel_out_valid", {63'b0, r32_out_valid}, 64'd0);

    // Table: one accept per vector, result must appear after exactly one edge.
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_tag   = 4'(i + 1);
      step();
      in_valid = 1'b0;
      chk({vecs[i].name, "_v32"},   {63'b0, r32_out_valid}, 64'd1);
      chk({vecs[i].name, "_imm32"}, {32'b0, r32_imm},       {32'b0, vecs[i].imm32});
      chk({vecs[i].name, "_fmt32"}, {61'b0, r32_fmt},       {61'b0, vecs[i].fmt32});
      chk({vecs[i].name, "_ill32"}, {63'b0, r32_ill},       {63'b0, vecs[i].ill32});
      chk({vecs[i].name, "_tag32"}, {60'b0, r32_tag},       64'(i + 1));
      chk({vecs[i].name, "_v64"},   {63'b0, r64_out_valid}, 64'd1);
      chk({vecs[i].name, "_imm64"}, r64_imm,                vecs[i].imm64);
      chk({vecs[i].name, "_fmt64"}, {61'b0, r64_fmt},       {61'b0, vecs[i].fmt64});
      chk({vecs[i].name, "_ill64"}, {63'b0, r64_ill},       {63'b0, vecs[i].ill64});
      $display("vec %0d %s instr=%h imm32=%h fmt32=%0d imm64=%h fmt64=%0d tag=%0d",
               i, vecs[i].name, vecs[i].instr, r32_imm, r32_fmt, r64_imm, r64_fmt, r32_tag);
    end
    step();
    chk("drain_empty", {63'b0, r32_out_valid}, 64'd0);

    // Backpressure: fill both entries, hold, then release and watch ordering.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h12345037;
    in_tag    = 4'd1;
    step();
    chk("bp1_tag",   {60'b0, r32_tag},      64'd1);
    chk("bp1_ready", {63'b0, r32_in_ready}, 64'd1);
    in_tag = 4'd2;
    step();
    chk("bp2_tag",   {60'b0, r32_tag},      64'd1);
    chk("bp2_ready", {63'b0, r32_in_ready}, 64'd0);
    in_tag = 4'd3;
    step();
    chk("bp3_tag",   {60'b0, r32_tag},      64'd1);
    chk("bp3_imm",   {32'b0, r32_imm},      64'h12345000);
    chk("bp3_ready", {63'b0, r32_in_ready}, 64'd0);
    step();
    chk("bp4_tag",   {60'b0, r32_tag},      64'd1);
    out_ready = 1'b1;
    step();
    chk("bp_out2",   {60'b0, r32_tag},      64'd2);
    chk("bp_out2_v", {63'b0, r32_out_valid}, 64'd1);
    $display("bp release tag=%0d", r32_tag);
    step();
    in_valid = 1'b0;
    chk("bp_out3",   {60'b0, r32_tag},      64'd3);
    chk("bp_out3_v", {63'b0, r32_out_valid}, 64'd1);
    $display("bp release tag=%0d", r32_tag);
    step();
    chk("bp_end_v",  {63'b0, r32_out_valid}, 64'd0);

    // Flush from the full state with a concurrent input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 4'd5;
    step();
    in_tag = 4'd6;
    step();
    chk("fl_full", {63'b0, r32_in_ready}, 64'd0);
    flush  = 1'b1;
    in_tag = 4'd7;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("fl_valid", {63'b0, r32_out_valid}, 64'd0);
    chk("fl_ready", {63'b0, r32_in_ready},  64'd1);
    step();
    chk("fl_none", {63'b0, r32_out_valid}, 64'd0);
    $display("flush done valid=%0d ready=%0d", r32_out_valid, r32_in_ready);

    // Asynchronous reset mid-stream.
    in_valid = 1'b1;
    in_instr = 32'hFFF00093;
    in_tag   = 4'd9;
    step();
    chk("ar_pre_v", {63'b0, r32_out_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {63'b0, r32_out_valid}, 64'd0);
    chk("ar_ready", {63'b0, r32_in_ready},  64'd0);
    chk("ar_tag",   {60'b0, r32_tag},       64'd0);
    chk("ar_v64",   {63'b0, r64_out_valid}, 64'd0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("ar_rel_ready", {63'b0, r32_in_ready},  64'd1);
    chk("ar_rel_valid", {63'b0, r32_out_valid}, 64'd0);
    in_valid = 1'b1;
    in_instr = 32'hFE000EE3;
    in_tag   = 4'hA;
    step();
    in_valid = 1'b0;
    chk("ar_restart_imm", {32'b0, r32_imm}, 64'hFFFFFFFC);
    chk("ar_restart_tag", {60'b0, r32_tag}, 64'hA);
    $display("restart tag=%0d imm=%h", r32_tag, r32_imm);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
